// File: rtl/rxuart.sv
// rxuart: receive-side 8N1 UART core.
// A two-flop synchroniser feeds a five-state receiver that samples each bit at
// its midpoint, pulses o_wr for every good byte and o_frame_err for every frame
// whose stop bit is low.
// Optional feature macro: RXUART_BREAK_EN adds the o_break output, which flags
// an all-zero frame and stays high until the line returns to idle.
module rxuart #(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd1250
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_uart_rx,
  output logic       o_wr,
  output logic [7:0] o_data,
  output logic       o_frame_err
`ifdef RXUART_BREAK_EN
  ,
  output logic       o_break
`endif
);

  // Half a bit lands the first sample mid start bit; a full bit thereafter.
  localparam logic [23:0] HALF_LOAD = (CLOCKS_PER_BAUD >> 1) - 24'd1;
  localparam logic [23:0] FULL_LOAD = CLOCKS_PER_BAUD - 24'd1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  logic        sync_reg, rx_s;
  state_t      state_reg, state_next;
  logic [23:0] baud_reg, baud_next;
  logic [2:0]  bit_reg, bit_next;
  logic [7:0]  shift_reg, shift_next;
  logic [7:0]  data_reg, data_next;
  logic        wr_reg, wr_next;
  logic        ferr_reg, ferr_next;
  logic        sample;
`ifdef RXUART_BREAK_EN
  logic        brk_reg, brk_next;
`endif

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_reg <= 1'b1;
      rx_s     <= 1'b1;
    end else begin
      sync_reg <= i_uart_rx;
      rx_s     <= sync_reg;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg <= IDLE;
      baud_reg  <= 24'd0;
      bit_reg   <= 3'd0;
      shift_reg <= 8'h00;
      data_reg  <= 8'h00;
      wr_reg    <= 1'b0;
      ferr_reg  <= 1'b0;
`ifdef RXUART_BREAK_EN
      brk_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      wr_reg    <= wr_next;
      ferr_reg  <= ferr_next;
`ifdef RXUART_BREAK_EN
      brk_reg   <= brk_next;
`endif
    end
  end

  assign sample = (baud_reg == 24'd0);

  // Next-state and datapath decisions. The counter is left at zero whenever
  // the receiver parks in IDLE or WAIT_IDLE so no stale count carries over.
  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    wr_next    = 1'b0;
    ferr_next  = 1'b0;
`ifdef RXUART_BREAK_EN
    brk_next   = brk_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          baud_next  = HALF_LOAD;
        end
      end
      START: begin
        if (sample) begin
          if (rx_s) begin
            // Line went back high before mid start bit: a glitch.
            state_next = IDLE;
          end else begin
            state_next = DATA;
            bit_next   = 3'd0;
            baud_next  = FULL_LOAD;
          end
        end else begin
          baud_next = baud_reg - 24'd1;
        end
      end
      DATA: begin
        if (sample) begin
          shift_next = {rx_s, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          baud_next  = FULL_LOAD;
          if (bit_reg == 3'd7) state_next = STOP;
        end else begin
          baud_next = baud_reg - 24'd1;
        end
      end
      STOP: begin
        if (sample) begin
          data_next = shift_reg;
          if (rx_s) begin
            wr_next    = 1'b1;
            state_next = IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = WAIT_IDLE;
`ifdef RXUART_BREAK_EN
            brk_next   = (shift_reg == 8'h00);
`endif
          end
        end else begin
          baud_next = baud_reg - 24'd1;
        end
      end
      WAIT_IDLE: begin
        // A low line here is never mistaken for a new start bit.
        if (rx_s) begin
          state_next = IDLE;
`ifdef RXUART_BREAK_EN
          brk_next   = 1'b0;
`endif
        end
      end
      default: begin
        state_next = IDLE;
        baud_next  = 24'd0;
      end
    endcase
  end

  assign o_wr        = wr_reg;
  assign o_data      = data_reg;
  assign o_frame_err = ferr_reg;
`ifdef RXUART_BREAK_EN
  assign o_break     = brk_reg;
`endif

endmodule

// File: tb/tb_rxuart.sv
// tb_rxuart: directed bench for rxuart with CLOCKS_PER_BAUD=16.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rxuart;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       wr;
  logic [7:0] data;
  logic       ferr;
`ifdef RXUART_BREAK_EN
  logic       brk;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  logic [7:0] wr_q[$];
  int wr_cyc[$];

  rxuart #(.CLOCKS_PER_BAUD(24'd16)) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_uart_rx  (rx),
    .o_wr       (wr),
    .o_data     (data),
    .o_frame_err(ferr)
`ifdef RXUART_BREAK_EN
    ,
    .o_break    (brk)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe cycle; a pulse wider than one cycle shows up twice.
  always @(negedge clk) begin
    if (wr) begin
      wr_q.push_back(data);
      wr_cyc.push_back(cyc);
      $display("rx byte %02h at cycle %0d", data, cyc);
    end
    if (ferr) begin
      ferr_cnt <= ferr_cnt + 1;
      $display("frame error at cycle %0d, o_data=%02h", cyc, data);
    end
    if (wr && ferr) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Start bit, eight data bits LSB first, then stop_bits of high stop level.
  task automatic send_byte(input logic [7:0] b);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(1'b1, CPB);
  endtask

  task automatic clear_log();
    wr_q.delete();
    wr_cyc.delete();
  endtask

  logic [7:0] hello [16] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20, 8'h57,
                             8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h20, 8'h0A, 8'h0D};

  initial begin
    int t0;
    int f0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_wr", 32'(wr), 32'h0);
    check("reset_data", 32'(data), 32'h00);
    check("reset_ferr", 32'(ferr), 32'h0);
`ifdef RXUART_BREAK_EN
    check("reset_break", 32'(brk), 32'h0);
`endif
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte 'H' with exact strobe latency: 2 sync + 8 + 144 + 1 cycles.
    clear_log();
    t0 = cyc;
    send_byte(8'h48);
    repeat (CPB) @(negedge clk);
    check("h_count", 32'(wr_q.size()), 32'd1);
    if (wr_q.size() > 0) begin
      check("h_data", 32'(wr_q[0]), 32'h48);
      check("h_latency", 32'(wr_cyc[0] - t0), 32'd155);
    end
    check("h_ferr", 32'(ferr_cnt), 32'd0);

    // Back-to-back string, one stop bit each.
    clear_log();
    for (int i = 0; i < 16; i++) send_byte(hello[i]);
    repeat (CPB) @(negedge clk);
    check("str_count", 32'(wr_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < wr_q.size()) check($sformatf("str_byte%0d", i), 32'(wr_q[i]), 32'(hello[i]));
    end
    check("str_ferr", 32'(ferr_cnt), 32'd0);

    // Glitch: 3 low cycles must not produce anything, then 0x55.
    clear_log();
    hold(1'b0, 3);
    hold(1'b1, 3 * CPB);
    check("glitch_wr", 32'(wr_q.size()), 32'd0);
    check("glitch_ferr", 32'(ferr_cnt), 32'd0);
    send_byte(8'h55);
    repeat (CPB) @(negedge clk);
    check("post_glitch_count", 32'(wr_q.size()), 32'd1);
    if (wr_q.size() > 0) check("post_glitch_data", 32'(wr_q[0]), 32'h55);

    // Frame error: 0xA5 with stop held low two bit times, then 0x3C.
    clear_log();
    f0 = ferr_cnt;
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(((8'hA5 >> i) & 8'h01) != 8'h00, CPB);
    hold(1'b0, 2 * CPB);
    hold(1'b1, CPB);
    check("ferr_pulses", 32'(ferr_cnt - f0), 32'd1);
    check("ferr_no_wr", 32'(wr_q.size()), 32'd0);
    check("ferr_data", 32'(data), 32'hA5);
    send_byte(8'h3C);
    repeat (CPB) @(negedge clk);
    check("after_ferr_count", 32'(wr_q.size()), 32'd1);
    if (wr_q.size() > 0) check("after_ferr_data", 32'(wr_q[0]), 32'h3C);
    check("never_both", 32'(both_cnt), 32'd0);

    // Reset after four data bits of 0xFF, then 0x12.
    clear_log();
    hold(1'b0, CPB);
    hold(1'b1, 4 * CPB);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset_data", 32'(data), 32'h00);
    check("midreset_wr", 32'(wr), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold(1'b1, 2 * CPB);
    check("aborted_no_wr", 32'(wr_q.size()), 32'd0);
    send_byte(8'h12);
    repeat (CPB) @(negedge clk);
    check("after_reset_count", 32'(wr_q.size()), 32'd1);
    if (wr_q.size() > 0) check("after_reset_data", 32'(wr_q[0]), 32'h12);

    // Line low for 12 bit times: frame error at the stop sample (155 cycles).
    clear_log();
    f0 = ferr_cnt;
    hold(1'b0, 155);
    check("brk_ferr_now", 32'(ferr), 32'h1);
`ifdef RXUART_BREAK_EN
    check("brk_set", 32'(brk), 32'h1);
`endif
    hold(1'b0, 30);
`ifdef RXUART_BREAK_EN
    check("brk_held", 32'(brk), 32'h1);
`endif
    hold(1'b0, 12 * CPB - 185);
    hold(1'b1, 4);
`ifdef RXUART_BREAK_EN
    check("brk_cleared", 32'(brk), 32'h0);
`endif
    hold(1'b1, 2 * CPB);
    check("brk_ferr_pulses", 32'(ferr_cnt - f0), 32'd1);
    check("brk_no_wr", 32'(wr_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
